us_cmd_fsm: RTL and testbench
=============================

# us_cmd_fsm

Consumer end of `us_cmd_fifo`: pops 128-bit upstream commands and converts each into a posted 32-bit-address Memory Write TLP. The TLP carries a 1 or 2 DW payload and is driven on the Spartan-6 PCIe TRN transmit interface (32-bit `trn_td`). The block sits between the command FIFO read port and the PCIe endpoint core TX port, and is the sole TX master in the upstream path.

## Interface
- `TBUF_AV_BIT`, 1, index of the `trn_tbuf_av` bit that flags posted-buffer availability.
- `clk`  in  1  user clock (`trn_clk` domain).
- `rst_n`  in  1  synchronous, active-low reset.
- `fifo_dout`  in  128  command word; valid the cycle after `fifo_rd_en`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO pop strobe.
- `cfg_completer_id`  in  16  requester ID placed in header DW1.
- `trn_lnk_up_n`  in  1  link up, active low.
- `trn_tbuf_av`  in  6  TX buffer availability.
- `trn_tdst_rdy_n`  in  1  core accepts beat, active low.
- `trn_td`  out  32  TX data.
- `trn_tsof_n`, `trn_teof_n`, `trn_tsrc_rdy_n`  out  1 each  TX framing, active low.
- `trn_tsrc_dsc_n`, `trn_terrfwd_n`  out  1 each  tied 1.
- `busy`  out  1  high in every state except IDLE.
- `tlp_count`  out  16  TLPs completed, wraps.
- `err_count`  out  8  commands dropped, saturates at 255.

## Operation
- Command fields:
  - `[31:0]` payload DW0.
  - `[63:32]` payload DW1.
  - `[95:64]` byte address; bits [1:0] are ignored.
  - `[97:96]` length code: 1 means 1 DW, 2 means 2 DW, 0 and 3 are illegal.
  - `[111:104]` tag.
  - All other bits are ignored.
- `fifo_rd_en` = (state==IDLE) & ~fifo_empty & ~trn_lnk_up_n & trn_tbuf_av[TBUF_AV_BIT]. This is combinational.
- States:
  - IDLE: goes to LATCH when `fifo_rd_en` is high.
  - LATCH: registers `fifo_dout`. Goes to HDR0 for a legal length. For an illegal length, goes to IDLE and increments `err_count`.
  - HDR0 → HDR1 → HDR2 → DAT0 → (DAT1 when length is 2) → IDLE.
  - Each beat state advances only on a cycle where `trn_tdst_rdy_n`=0.
- Beats:
  - HDR0 = {1'b0, 2'b10, 5'b00000, 14'b0, len[9:0]}, so 0x40000001 or 0x40000002.
  - HDR1 = {cfg_completer_id, tag, lastBE, firstBE}. firstBE=4'hF. lastBE=4'h0 for 1 DW, 4'hF for 2 DW.
  - HDR2 = {addr[31:2], 2'b00}.
  - DAT0 = payload DW0.
  - DAT1 = payload DW1.
- Framing:
  - `trn_tsrc_rdy_n`=0 in HDR0 through the last data state, otherwise 1.
  - `trn_tsof_n`=0 only in HDR0.
  - `trn_teof_n`=0 only in the last data state.
- `cfg_completer_id` is sampled in LATCH.
- `tlp_count` increments on acceptance of the EOF beat.
- Link loss mid-TLP does not abort the TLP. `trn_lnk_up_n` and `trn_tbuf_av` gate only the pop.

## Timing
- Reset values:
  - state IDLE.
  - `fifo_rd_en`=0 while `rst_n`=0.
  - `trn_td`=0.
  - `trn_tsof_n`=`trn_teof_n`=`trn_tsrc_rdy_n`=1.
  - `busy`=0, `tlp_count`=0, `err_count`=0.
  - Internal command register = 0.
- All TX outputs are registered, or decoded from the registered state only; there is no combinational path from `trn_tdst_rdy_n` to `trn_td`.
- Latency, with the pop at edge N: LATCH at N+1, SOF beat presented in cycle N+2.
  - 1 DW TLP: EOF in cycle N+5; IDLE and the next pop possible at N+6, giving a 6-cycle command period.
  - 2 DW TLP: 7-cycle command period.
- Backpressure: while `trn_tdst_rdy_n`=1, `trn_td` and all framing outputs hold their values unchanged.
- Illegal command: LATCH → IDLE. No TX activity, and the next pop is possible 2 cycles after the previous one.
- Reset asserted mid-TLP: on the next edge all outputs return to their reset values. The partial TLP is abandoned; the core is reset with the link in that case.
- `err_count` holds at 255. `tlp_count` wraps from 0xFFFF to 0.

## Test plan
- 1 DW write: cmd {len=1, addr=0x1000_0004, tag=0x5A, DW0=0xDEADBEEF}, `cfg_completer_id`=0x0100, `trn_tdst_rdy_n`=0 → beats 0x40000001, 0x01005A0F, 0x10000004, 0xDEADBEEF. SOF on beat 1, EOF on beat 4, `tlp_count`=1.
- 2 DW write: len=2, addr=0x2000_0008, DW0=0x11111111, DW1=0x22222222 → HDR0 0x40000002, HDR1 BE field 0xFF, 5 beats, EOF on 0x22222222.
- Backpressure: `trn_tdst_rdy_n` toggles with a random 50% pattern during 8 queued commands → every beat is held stable until accepted, beat order matches the FIFO order, `tlp_count`=8.
- Illegal length: cmd len=0 followed by a legal cmd → no TX for the first, `err_count`=1, second TLP correct. Pop 256 illegal commands → `err_count`=255.
- Gating: `trn_tbuf_av[1]`=0 or `trn_lnk_up_n`=1 with the FIFO non-empty → `fifo_rd_en` stays 0. Releasing the gate → pop on the same cycle.
- Reset mid-TLP: `rst_n`=0 during HDR2 → next cycle `trn_tsrc_rdy_n`=1, `busy`=0, counters 0. After release, the next command is sent complete from SOF.

Source files
------------

// File: rtl/us_cmd_fsm_if.sv
// FIFO read port and TRN transmit port seen by the upstream command FSM.
// The master side is the FSM; the slave side is the FIFO plus the PCIe core.
interface us_cmd_fsm_if;
  // Command FIFO read port
  logic [127:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_rd_en;

  // TRN transmit port
  logic [31:0]  trn_td;
  logic         trn_tsof_n;
  logic         trn_teof_n;
  logic         trn_tsrc_rdy_n;
  logic         trn_tdst_rdy_n;
  logic         trn_tsrc_dsc_n;
  logic         trn_terrfwd_n;

  modport master (
    input  fifo_dout,
    input  fifo_empty,
    output fifo_rd_en,
    output trn_td,
    output trn_tsof_n,
    output trn_teof_n,
    output trn_tsrc_rdy_n,
    input  trn_tdst_rdy_n,
    output trn_tsrc_dsc_n,
    output trn_terrfwd_n
  );

  modport slave (
    output fifo_dout,
    output fifo_empty,
    input  fifo_rd_en,
    input  trn_td,
    input  trn_tsof_n,
    input  trn_teof_n,
    input  trn_tsrc_rdy_n,
    output trn_tdst_rdy_n,
    input  trn_tsrc_dsc_n,
    input  trn_terrfwd_n
  );
endinterface

// File: rtl/us_cmd_fsm.sv
// Upstream command FSM: pops 128-bit commands from us_cmd_fifo and emits each one as a
// posted 3DW-header Memory Write TLP (1 or 2 DW payload) on the 32-bit TRN TX port.
module us_cmd_fsm #(
  parameter int unsigned TBUF_AV_BIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  us_cmd_fsm_if.master bus,
  input  logic [15:0]  cfg_completer_id,
  input  logic         trn_lnk_up_n,
  input  logic [5:0]   trn_tbuf_av,
  output logic         busy,
  output logic [15:0]  tlp_count,
  output logic [7:0]   err_count
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLatch = 3'd1;
  localparam logic [2:0] StHdr0  = 3'd2;
  localparam logic [2:0] StHdr1  = 3'd3;
  localparam logic [2:0] StHdr2  = 3'd4;
  localparam logic [2:0] StDat0  = 3'd5;
  localparam logic [2:0] StDat1  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] dw0_q, dw1_q;
  logic [29:0] addr_q;
  logic [7:0]  tag_q;
  logic [15:0] cid_q;
  logic        two_dw_q;
  logic [15:0] tlp_count_q;
  logic [7:0]  err_count_q;
  logic [31:0] td;

  logic len_legal;
  logic accept;
  logic last_beat;
  logic eof_ack;
  logic in_tlp;

  // Only codes 1 and 2 are legal, i.e. exactly one of the two length bits set.
  assign len_legal = ^bus.fifo_dout[97:96];
  assign accept    = ~bus.trn_tdst_rdy_n;
  assign last_beat = ((state_q == StDat0) & ~two_dw_q) | (state_q == StDat1);
  assign eof_ack   = last_beat & accept;
  assign in_tlp    = (state_q == StHdr0) | (state_q == StHdr1) | (state_q == StHdr2) |
                     (state_q == StDat0) | (state_q == StDat1);

  // Pop gate: only from IDLE, and only with link up and posted credits available.
  assign bus.fifo_rd_en = rst_n & (state_q == StIdle) & ~bus.fifo_empty & ~trn_lnk_up_n &
                          trn_tbuf_av[TBUF_AV_BIT];

  // Next-state logic; beat states move only when the core takes the beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.fifo_rd_en) state_d = StLatch;
      StLatch: state_d = len_legal ? StHdr0 : StIdle;
      StHdr0:  if (accept) state_d = StHdr1;
      StHdr1:  if (accept) state_d = StHdr2;
      StHdr2:  if (accept) state_d = StDat0;
      StDat0:  if (accept) state_d = two_dw_q ? StDat1 : StIdle;
      StDat1:  if (accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Beat data decoded from registered state and latched command only, so backpressure
  // cannot reach trn_td combinationally and a stalled beat holds by construction.
  always_comb begin
    td = '0;
    case (state_q)
      StHdr0:  td = {1'b0, 2'b10, 5'b00000, 14'b0, 8'b0, two_dw_q ? 2'd2 : 2'd1};
      StHdr1:  td = {cid_q, tag_q, {4{two_dw_q}}, 4'hF};
      StHdr2:  td = {addr_q, 2'b00};
      StDat0:  td = dw0_q;
      StDat1:  td = dw1_q;
      default: td = '0;
    endcase
  end

  assign bus.trn_td         = td;
  assign bus.trn_tsrc_rdy_n = ~in_tlp;
  assign bus.trn_tsof_n     = ~(state_q == StHdr0);
  assign bus.trn_teof_n     = ~last_beat;
  assign bus.trn_tsrc_dsc_n = 1'b1;
  assign bus.trn_terrfwd_n  = 1'b1;

  assign busy      = (state_q != StIdle);
  assign tlp_count = tlp_count_q;
  assign err_count = err_count_q;

  // State, command latch and statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dw0_q       <= '0;
      dw1_q       <= '0;
      addr_q      <= '0;
      tag_q       <= '0;
      cid_q       <= '0;
      two_dw_q    <= 1'b0;
      tlp_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StLatch) begin
        dw0_q    <= bus.fifo_dout[31:0];
        dw1_q    <= bus.fifo_dout[63:32];
        addr_q   <= bus.fifo_dout[95:66];
        tag_q    <= bus.fifo_dout[111:104];
        two_dw_q <= bus.fifo_dout[97];
        cid_q    <= cfg_completer_id;
        if (!len_legal && (err_count_q != 8'hFF)) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end
      if (eof_ack) begin
        tlp_count_q <= tlp_count_q + 16'd1;
      end
    end
  end

  // Command bits that carry no meaning for a memory write.
  logic unused_fifo_bits;
  assign unused_fifo_bits = ^{bus.fifo_dout[127:112], bus.fifo_dout[103:98],
                              bus.fifo_dout[65:64]};

endmodule

// File: tb/tb_us_cmd_fsm.sv
// Directed bench for us_cmd_fsm with a FIFO model and a beat scoreboard.
module tb_us_cmd_fsm;

  typedef struct packed {
    logic [31:0] td;
    logic        sof;
    logic        eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cid;
  logic        lnk_up_n;
  logic [5:0]  tbuf_av;
  logic        busy;
  logic [15:0] tlp_count;
  logic [7:0]  err_count;

  us_cmd_fsm_if bus ();

  us_cmd_fsm #(.TBUF_AV_BIT(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .cfg_completer_id (cid),
    .trn_lnk_up_n     (lnk_up_n),
    .trn_tbuf_av      (tbuf_av),
    .busy             (busy),
    .tlp_count        (tlp_count),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          n_push   = 0;
  int          n_pop    = 0;
  bit          bp_en    = 1'b0;
  logic [127:0] fq[$];
  beat_t       exp_q[$];
  int          pop_t[$];
  bit          hold_v   = 1'b0;
  beat_t       hold_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // FIFO model: data appears the cycle after the pop strobe.
  assign bus.fifo_empty = (n_push == n_pop);
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.fifo_rd_en) begin
      if (fq.size() == 0) begin
        check("pop_when_empty", 1, 0);
      end else begin
        pop_t.push_back(cyc);
        bus.fifo_dout <= fq.pop_front();
        n_pop <= n_pop + 1;
      end
    end
  end

  // Core-side ready: always ready, or a random 50% pattern when backpressure is on.
  always @(posedge clk) begin
    #1;
    bus.trn_tdst_rdy_n = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Beat monitor: stalled beats must hold; accepted beats are compared in order.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    if (rst_n && !bus.trn_tsrc_rdy_n) begin
      cur = {bus.trn_td, ~bus.trn_tsof_n, ~bus.trn_teof_n};
      if (hold_v) check("held_beat", cur, hold_b);
      if (!bus.trn_tdst_rdy_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_b = cur;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic push_cmd(input logic [1:0] len, input logic [31:0] addr, input logic [7:0] tag,
                          input logic [31:0] d0, input logic [31:0] d1);
    logic [127:0] c;
    c            = '0;
    c[31:0]      = d0;
    c[63:32]     = d1;
    c[95:64]     = addr;
    c[97:96]     = len;
    c[103:98]    = 6'h2A;
    c[111:104]   = tag;
    c[127:112]   = 16'hA5A5;
    fq.push_back(c);
    n_push++;
    if (len == 2'd1 || len == 2'd2) begin
      exp_q.push_back({32'h4000_0000 | {30'b0, len}, 1'b1, 1'b0});
      exp_q.push_back({cid, tag, (len == 2'd2) ? 4'hF : 4'h0, 4'hF, 2'b00});
      exp_q.push_back({addr[31:2], 2'b00, 2'b00});
      exp_q.push_back({d0, 1'b0, len == 2'd1});
      if (len == 2'd2) exp_q.push_back({d1, 2'b01});
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int k = 0;
    while (k < budget && !(exp_q.size() == 0 && n_push == n_pop && !busy)) begin
      step();
      k++;
    end
    check(tag, k < budget, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n    = 1'b0;
    cid      = 16'h0100;
    lnk_up_n = 1'b0;
    tbuf_av  = 6'h3F;
    repeat (3) step();

    // Reset state
    check("rst_td", bus.trn_td, 0);
    check("rst_sof", bus.trn_tsof_n, 1);
    check("rst_eof", bus.trn_teof_n, 1);
    check("rst_srdy", bus.trn_tsrc_rdy_n, 1);
    check("rst_busy", busy, 0);
    check("rst_tlp", tlp_count, 0);
    check("rst_err", err_count, 0);
    check("tied_dsc", bus.trn_tsrc_dsc_n, 1);
    check("tied_errfwd", bus.trn_terrfwd_n, 1);

    // 1 DW writes, back to back; second has non-zero address low bits
    push_cmd(2'd1, 32'h1000_0004, 8'h5A, 32'hDEADBEEF, 32'h0);
    push_cmd(2'd1, 32'h1000_0007, 8'hC3, 32'h0BAD_F00D, 32'hFFFF_FFFF);
    step();
    check("rst_rd_en", bus.fifo_rd_en, 0);
    pop_t.delete();
    rst_n = 1'b1;
    #1;
    check("rd_en_after_rst", bus.fifo_rd_en, 1);
    step();
    check("latch_busy", busy, 1);
    check("latch_srdy", bus.trn_tsrc_rdy_n, 1);
    step();
    check("sof_latency", bus.trn_tsof_n, 0);
    drain(100, "drain_1dw");
    check("tlp_1dw", tlp_count, 2);
    check("period_1dw", pop_t[1] - pop_t[0], 6);

    // 2 DW writes
    pop_t.delete();
    push_cmd(2'd2, 32'h2000_0008, 8'h33, 32'h1111_1111, 32'h2222_2222);
    push_cmd(2'd2, 32'h2000_0010, 8'h34, 32'h3333_3333, 32'h4444_4444);
    drain(100, "drain_2dw");
    check("tlp_2dw", tlp_count, 4);
    check("period_2dw", pop_t[1] - pop_t[0], 7);

    // Illegal length followed by a legal command
    pop_t.delete();
    push_cmd(2'd0, 32'h3000_0000, 8'h77, 32'hBBBB_BBBB, 32'hCCCC_CCCC);
    push_cmd(2'd1, 32'h3000_0040, 8'h78, 32'h1234_5678, 32'h0);
    drain(100, "drain_illegal");
    check("err_one", err_count, 1);
    check("tlp_after_illegal", tlp_count, 5);
    check("period_illegal", pop_t[1] - pop_t[0], 2);

    // Saturation of the drop counter
    for (int i = 0; i < 256; i++) begin
      push_cmd((i % 2 == 0) ? 2'd0 : 2'd3, 32'($urandom), 8'(i), 32'($urandom), 32'h0);
    end
    drain(2000, "drain_sat");
    check("err_sat", err_count, 255);
    check("tlp_after_sat", tlp_count, 5);

    // Random backpressure over 8 queued commands
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_cmd(($urandom_range(0, 1) == 1) ? 2'd2 : 2'd1, 32'($urandom), 8'($urandom),
               32'($urandom), 32'($urandom));
    end
    drain(1000, "drain_bp");
    bp_en = 1'b0;
    check("tlp_bp", tlp_count, 13);

    // Gating by posted-buffer availability
    tbuf_av = 6'h3D;
    push_cmd(2'd1, 32'h4000_0000, 8'h01, 32'hAAAA_5555, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("gate_tbuf_rd_en", bus.fifo_rd_en, 0);
    end
    check("gate_tbuf_busy", busy, 0);
    tbuf_av = 6'h3F;
    #1;
    check("gate_tbuf_release", bus.fifo_rd_en, 1);
    drain(100, "drain_gate_tbuf");

    // Gating by link state
    lnk_up_n = 1'b1;
    push_cmd(2'd2, 32'h4000_0100, 8'h02, 32'h5555_AAAA, 32'h6666_7777);
    for (int i = 0; i < 3; i++) begin
      step();
      check("gate_link_rd_en", bus.fifo_rd_en, 0);
    end
    lnk_up_n = 1'b0;
    #1;
    check("gate_link_release", bus.fifo_rd_en, 1);
    drain(100, "drain_gate_link");
    check("tlp_gate", tlp_count, 15);

    // Reset during HDR2 abandons the TLP
    push_cmd(2'd1, 32'h5000_0010, 8'h22, 32'hCAFE_F00D, 32'h0);
    k = 0;
    while (bus.trn_tsof_n && k < 20) begin
      step();
      k++;
    end
    check("wait_sof", k < 20, 1);
    step();
    step();
    check("hdr2_td", bus.trn_td, 32'h5000_0010);
    rst_n = 1'b0;
    step();
    check("midrst_srdy", bus.trn_tsrc_rdy_n, 1);
    check("midrst_busy", busy, 0);
    check("midrst_tlp", tlp_count, 0);
    check("midrst_err", err_count, 0);
    check("midrst_td", bus.trn_td, 0);
    check("midrst_eof", bus.trn_teof_n, 1);
    exp_q.delete();
    rst_n = 1'b1;
    push_cmd(2'd2, 32'h6000_0004, 8'h99, 32'h0102_0304, 32'h0506_0708);
    drain(100, "drain_after_rst");
    check("tlp_after_rst", tlp_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
